// File: rtl/hazard_stall_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_if
// Brief    : Pipeline-side signals of the hazard/stall unit, grouped.
// Revision : 1.0
// ============================================================================
interface hazard_stall_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        id_branch;
    logic        id_jump_reg;
    logic        branch_taken;
    logic        id_jump;
    logic        ex_mem_read;
    logic        ex_reg_write;
    logic [4:0]  ex_write_reg;
    logic        mem_mem_read;
    logic [4:0]  mem_write_reg;
    logic        control;
    logic        pc_write;
    logic        ifid_write;
    logic        if_flush;
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_branch, id_jump_reg, branch_taken,
               id_jump, ex_mem_read, ex_reg_write, ex_write_reg,
               mem_mem_read, mem_write_reg,
        input  control, pc_write, ifid_write, if_flush, stall_cycles, flush_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_branch, id_jump_reg, branch_taken,
               id_jump, ex_mem_read, ex_reg_write, ex_write_reg,
               mem_mem_read, mem_write_reg,
        output control, pc_write, ifid_write, if_flush, stall_cycles, flush_count
    );
endinterface
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_unit
// Brief    : Load-use / branch-operand stall and IF flush control with
//            saturating stall and flush performance counters.
// Revision : 1.0
// ============================================================================
module hazard_stall_unit (
    input  wire            clk,
    input  wire            rst_n,
    hazard_stall_if.slave  hz
);
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_nxt;
    logic [1:0]  w_need;
    logic        w_stall;
    logic        w_redirect;
    logic        w_flush;
    logic        w_ctrl_xfer;
    logic        w_match_ex;
    logic        w_match_ex_cx;
    logic        w_match_mem_cx;
    logic [15:0] r_stall_cycles;
    logic [15:0] r_flush_count;

    // Branch/jr operand matches: jr reads only Rs, so Rt counts for branches only.
    always_comb begin
        w_ctrl_xfer    = hz.id_branch | hz.id_jump_reg;
        w_match_ex     = (hz.ex_write_reg != 5'd0) &&
                         ((hz.ex_write_reg == hz.id_rs) ||
                          (hz.id_uses_rt && (hz.ex_write_reg == hz.id_rt)));
        w_match_ex_cx  = (hz.ex_write_reg != 5'd0) &&
                         ((hz.ex_write_reg == hz.id_rs) ||
                          (hz.id_branch && hz.id_uses_rt && (hz.ex_write_reg == hz.id_rt)));
        w_match_mem_cx = (hz.mem_write_reg != 5'd0) &&
                         ((hz.mem_write_reg == hz.id_rs) ||
                          (hz.id_branch && hz.id_uses_rt && (hz.mem_write_reg == hz.id_rt)));
    end

    always_comb begin
        w_need = 2'd0;
        if (hz.ex_mem_read && w_match_ex)
            w_need = 2'd1;
        if (w_ctrl_xfer && hz.ex_reg_write && !hz.ex_mem_read && w_match_ex)
            w_need = 2'd1;
        if (w_ctrl_xfer && hz.mem_mem_read && w_match_mem_cx)
            w_need = 2'd1;
        if (w_ctrl_xfer && hz.ex_mem_read && w_match_ex_cx)
            w_need = 2'd2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Only a two-cycle need leaves RUN; STALL returns to RUN as Cnt reaches 0.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_stall = (w_need != 2'd0);
                if (w_need == 2'd2) begin
                    w_state_nxt = ST_STALL;
                    w_cnt_nxt   = w_need - 2'd1;
                end
            end
            ST_STALL: begin
                w_stall   = (r_cnt != 2'd0);
                w_cnt_nxt = (r_cnt != 2'd0) ? (r_cnt - 2'd1) : 2'd0;
                if (r_cnt <= 2'd1)
                    w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = 2'd0;
            end
        endcase
    end

    always_comb begin
        w_redirect = (hz.id_branch & hz.branch_taken) | hz.id_jump | hz.id_jump_reg;
        w_flush    = rst_n & ~w_stall & w_redirect;
    end

    assign hz.control      = rst_n & ~w_stall;
    assign hz.pc_write     = rst_n & ~w_stall;
    assign hz.ifid_write   = rst_n & ~w_stall;
    assign hz.if_flush     = w_flush;
    assign hz.stall_cycles = r_stall_cycles;
    assign hz.flush_count  = r_flush_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= 16'd0;
            r_flush_count  <= 16'd0;
        end else begin
            if (w_stall && (r_stall_cycles != c_CNT_MAX))
                r_stall_cycles <= r_stall_cycles + 16'd1;
            if (w_flush && (r_flush_count != c_CNT_MAX))
                r_flush_count <= r_flush_count + 16'd1;
        end
    end
endmodule
`default_nettype wire

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 Clk  in  1  system clock; all state updates on the rising edge.
REQ-002 Rst  in  1  reset, asynchronous, active-low.
REQ-003 ID_Rs, ID_Rt  in  5 each  source register numbers of the instruction in ID.
REQ-004 ID_UsesRt  in  1  high when the ID instruction reads Rt as an operand.
REQ-005 ID_Branch  in  1  high when the ID instruction is a conditional branch compared in ID (reads Rs and Rt).
REQ-006 ID_JumpReg  in  1  high when the ID instruction is jr or jalr (reads Rs in ID).
REQ-007 BranchTaken  in  1  ID branch comparator result; meaningful only when ID_Branch=1.
REQ-008 ID_Jump  in  1  high when the ID instruction is an unconditional j or jal.
REQ-009 EX_MemRead, EX_RegWrite  in  1 each  control bits of the instruction in EX.
REQ-010 EX_WriteReg  in  5  destination register of the EX instruction.
REQ-011 MEM_MemRead  in  1  high when the MEM instruction is a load.
REQ-012 MEM_WriteReg  in  5  destination register of the MEM instruction.
REQ-013 Control  out  1  1 = pass ID control signals; 0 = insert a bubble. Drives the ID control mux select.
REQ-014 PCWrite, IFIDWrite  out  1 each  enable bits for the PC and the IF/ID register.
REQ-015 IF_Flush  out  1  clear the IF/ID register on a taken redirect.
REQ-016 StallCycles, FlushCount  out  16 each  saturating performance counters.

Function
REQ-017 States SHALL be RUN and STALL, with a 2-bit down-counter Cnt.
REQ-018 A register match (Reg) SHALL be true only when Reg!=0 and Reg equals ID_Rs, or Reg equals ID_Rt with ID_UsesRt=1.
REQ-019 In RUN, Need SHALL be computed combinationally, taking the maximum of the cases that apply:
- Case 1: EX_MemRead and match(EX_WriteReg) gives Need=1.
- Case 2: (ID_Branch or ID_JumpReg) and EX_RegWrite and not EX_MemRead and match(EX_WriteReg) gives Need=1.
- Case 3: (ID_Branch or ID_JumpReg) and EX_MemRead and match(EX_WriteReg) gives Need=2.
- Case 4: (ID_Branch or ID_JumpReg) and MEM_MemRead and match(MEM_WriteReg) gives Need=1.
- Otherwise Need=0.
REQ-020 For cases 3 and 4, the Rt match SHALL apply only for ID_Branch; jr and jalr match on Rs only.
REQ-021 Stall cycle: Control, PCWrite and IFIDWrite SHALL all be 0 in the same cycle when (RUN and Need>0) or (STALL and Cnt>0).
REQ-022 Transition RUN->STALL with Cnt<=Need-1 SHALL occur only when Need=2. Need=1 stays in RUN.
REQ-023 In STALL, hazard detection SHALL be masked. Each cycle Cnt decrements, and when Cnt reaches 0 the state returns to RUN in the next cycle.
REQ-024 Total stall length SHALL be exactly Need cycles.
REQ-025 IF_Flush SHALL be 1 combinationally when not stalling and either (ID_Branch and BranchTaken) or ID_Jump or ID_JumpReg.
REQ-026 IF_Flush SHALL be forced to 0 during any stall cycle. The redirect is taken on the first non-stall cycle.
REQ-027 Stall and flush SHALL never both be asserted.
REQ-028 When not stalling, Control, PCWrite and IFIDWrite SHALL each be 1.
REQ-029 StallCycles SHALL increment once per stall cycle. FlushCount SHALL increment once per cycle with IF_Flush=1. Both SHALL saturate at 16'hFFFF.
REQ-030 Detection SHALL be purely combinational from the current inputs, adding 0 cycles of latency.

Reset
REQ-031 While Rst=0, the block SHALL hold: State=RUN, Cnt=0, StallCycles=0, FlushCount=0.
REQ-032 While Rst=0, outputs SHALL be Control=0, PCWrite=0, IFIDWrite=0, IF_Flush=0, independent of inputs.
REQ-033 On the first rising edge after Rst rises, the block SHALL evaluate in RUN.
REQ-034 Reset asserted in STALL SHALL abort the stall immediately, without waiting for a clock edge.

Verification
REQ-035 Load-use: EX_MemRead=1, EX_WriteReg=8, ID_Rs=8 -> Control=0 for exactly 1 cycle, then 1. StallCycles=1.
REQ-036 Branch after load: ID_Branch=1, EX_MemRead=1, EX_WriteReg=9, ID_Rt=9 -> 2 stall cycles (RUN, then STALL with Cnt=1), then IF_Flush=1 if BranchTaken=1. StallCycles=2, FlushCount=1.
REQ-037 $zero guard: EX_MemRead=1, EX_WriteReg=0, ID_Rs=0 -> no stall, Control=1.
REQ-038 Simultaneous events: taken branch with an EX ALU dependence (case 2) -> IF_Flush=0 in the stall cycle, IF_Flush=1 in the following cycle.
REQ-039 Reset mid-stall: drop Rst while in STALL with Cnt=1 -> outputs go to 0 immediately, counters clear to 0, and after release Control=1 with no residual stall.
REQ-040 Saturation: preload StallCycles to 16'hFFFE and force 3 stall cycles -> StallCycles holds at 16'hFFFF.
